// File: rtl/apr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : apr_pkg
// Purpose : Shared types and widths for the apr sweep sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package apr_pkg;

  // Default operand width of the apr data path.
  localparam int APR_W     = 8;
  // Width of the running checksum.
  localparam int APR_CHK_W = 16;

  // Sweep sequencer states. The ST_ prefix keeps the literals clear of the
  // SETTLE parameter name used by the modules importing this package.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } apr_sweep_state_e;

endpackage
`default_nettype wire

// File: rtl/apr_settle_timer.sv
`default_nettype none
// ============================================================================
// Module  : apr_settle_timer
// Purpose : Load/count/expire timer that measures the settle window after a
//           sweep point is driven. Expire is a constant 1 when SETTLE is 0.
// Rev     : 1.0  initial release
// ============================================================================
module apr_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  // Count value seen in the final settle cycle.
  localparam logic [3:0] c_last = 4'((SETTLE == 0) ? 0 : SETTLE - 1);

  logic [3:0] cnt_q;

  // Count settle cycles; restart from zero whenever a new point is driven.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= 4'd0;
    end else if (load_i) begin
      cnt_q <= 4'd0;
    end else if (en_i && (cnt_q != 4'hF)) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign expire_o = (SETTLE == 0) || (en_i && (cnt_q == c_last));

endmodule
`default_nettype wire

// File: rtl/apr_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : apr_sweep_ctrl
// Purpose : Clocked exhaustive 0..LAST sweep of the apr A/B operands. Each
//           point is held for SETTLE cycles, then A_OUT/B_OUT are captured,
//           streamed out with their index and folded into a 16-bit checksum.
//           Define APR_SWEEP_CHECK_EN to add the err_cnt port, which counts
//           points whose outputs differ from the driven index.
// Rev     : 1.0  initial release
// ============================================================================
module apr_sweep_ctrl
  import apr_pkg::*;
#(
  parameter int WIDTH  = APR_W,
  parameter int SETTLE = 2,
  parameter int LAST   = 255
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     A,
  output logic [WIDTH-1:0]     B,
  input  logic [WIDTH-1:0]     dut_a,
  input  logic [WIDTH-1:0]     dut_b,
  output logic                 smp_valid,
  output logic [WIDTH-1:0]     smp_idx,
  output logic [WIDTH-1:0]     smp_a,
  output logic [WIDTH-1:0]     smp_b,
  output logic [APR_CHK_W-1:0] chksum
`ifdef APR_SWEEP_CHECK_EN
  ,
  output logic [WIDTH:0]       err_cnt
`endif
);

  localparam logic [WIDTH-1:0] c_last     = WIDTH'(LAST);
  // A zero settle time skips the SETTLE state entirely.
  localparam apr_sweep_state_e c_point_st = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

  apr_sweep_state_e       state_q, state_d;
  logic [WIDTH-1:0]       idx_q;
  logic                   busy_q, done_q, smp_valid_q;
  logic [WIDTH-1:0]       smp_idx_q, smp_a_q, smp_b_q;
  logic [APR_CHK_W-1:0]   chksum_q;
  logic                   w_expire, w_tmr_load, w_is_last, w_take_start;
  logic [2*WIDTH-1:0]     w_cat;
  logic [APR_CHK_W-1:0]   w_word;

  assign w_is_last    = (idx_q == c_last);
  assign w_take_start = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
  assign w_tmr_load   = (state_d == ST_SETTLE) && (state_q != ST_SETTLE);
  assign w_cat        = {dut_a, dut_b};

  // Fit the {dut_a,dut_b} sample word to the checksum width.
  if (2 * WIDTH >= APR_CHK_W) begin : g_word_trunc
    assign w_word = w_cat[APR_CHK_W-1:0];
  end else begin : g_word_ext
    assign w_word = {{(APR_CHK_W - 2 * WIDTH){1'b0}}, w_cat};
  end

  apr_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load_i   (w_tmr_load),
    .en_i     (state_q == ST_SETTLE),
    .expire_o (w_expire)
  );

  // Next sweep state; start is only honoured when no sweep is running.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = c_point_st;
      ST_SETTLE:        if (w_expire) state_d = ST_SAMPLE;
      ST_SAMPLE:        state_d = w_is_last ? ST_DONE : c_point_st;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Sweep FSM with registered status, point index, capture and checksum.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      smp_valid_q <= 1'b0;
      smp_idx_q   <= '0;
      smp_a_q     <= '0;
      smp_b_q     <= '0;
      chksum_q    <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
      done_q      <= (state_d == ST_DONE);
      smp_valid_q <= 1'b0;
      if (w_take_start) begin
        idx_q    <= '0;
        chksum_q <= '0;
      end
      if (state_q == ST_SAMPLE) begin
        smp_valid_q <= 1'b1;
        smp_idx_q   <= idx_q;
        smp_a_q     <= dut_a;
        smp_b_q     <= dut_b;
        chksum_q    <= chksum_q + w_word;
        // The last point terminates by compare, so idx never wraps.
        if (!w_is_last) idx_q <= idx_q + 1'b1;
      end
    end
  end

`ifdef APR_SWEEP_CHECK_EN
  logic [WIDTH:0] err_q;
  logic           w_mismatch;

  assign w_mismatch = (dut_a != idx_q) || (dut_b != idx_q);

  // Saturating count of points whose outputs differ from the driven index.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= '0;
    end else if (w_take_start) begin
      err_q <= '0;
    end else if ((state_q == ST_SAMPLE) && w_mismatch && (err_q != '1)) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign err_cnt = err_q;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign A         = idx_q;
  assign B         = idx_q;
  assign smp_valid = smp_valid_q;
  assign smp_idx   = smp_idx_q;
  assign smp_a     = smp_a_q;
  assign smp_b     = smp_b_q;
  assign chksum    = chksum_q;

endmodule
`default_nettype wire
